// File: rtl/mem_job_sequencer.sv
// Block-memory job sequencer: reads N blocks, streams each through compute, writes results back, posts a status word.
// Optional build macro MEM_SEQ_ABORT_EN adds in_abort to cut a job short with an error status.
module mem_job_sequencer #(
  parameter int SIZE         = 1024,
  parameter int LOG_SIZE     = 10,
  parameter int BLOCKS       = 4,
  parameter int CELL_WIDTH   = 32,
  parameter int WIDTH        = CELL_WIDTH * BLOCKS,
  parameter int READ_LATENCY = 1
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
`ifdef MEM_SEQ_ABORT_EN
  input  logic                  in_abort,
`endif
  input  logic                  in_start,
  input  logic [LOG_SIZE-1:0]   in_src_addr,
  input  logic [LOG_SIZE-1:0]   in_dst_addr,
  input  logic [LOG_SIZE-1:0]   in_count,
  output logic                  out_busy,
  output logic                  out_done,
  output logic [LOG_SIZE-1:0]   out_mem_address,
  output logic [WIDTH-1:0]      out_mem_data,
  output logic                  out_mem_read_en,
  output logic                  out_mem_write_en,
  input  logic [WIDTH-1:0]      in_mem_data,
  output logic [CELL_WIDTH-1:0] out_mem_status,
  output logic                  out_mem_write_status_en,
  input  logic [CELL_WIDTH-1:0] in_mem_config,
  output logic [WIDTH-1:0]      out_rd_data,
  output logic                  out_rd_valid,
  input  logic                  in_rd_ready,
  input  logic [WIDTH-1:0]      in_wr_data,
  input  logic                  in_wr_valid,
  output logic                  out_wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_PRESENT, S_COLLECT, S_WR, S_STATUS, S_DONE
  } state_t;

  state_t                r_state;
  logic [LOG_SIZE-1:0]   r_src, r_dst, r_count, r_k;
  logic [2:0]            r_lat;
  logic [LOG_SIZE-1:0]   r_addr;
  logic [WIDTH-1:0]      r_mem_data, r_rd_data;
  logic [CELL_WIDTH-1:0] r_status;
  logic                  r_read_en, r_write_en, r_status_en;
  logic                  r_rd_valid, r_wr_ready, r_done;
  logic [LOG_SIZE-1:0]   w_k_next;
  logic                  w_unused_cfg;

  assign w_k_next     = r_k + LOG_SIZE'(1);
  assign w_unused_cfg = ^in_mem_config[CELL_WIDTH-1:1];

  // Block base address; the product is truncated so addresses wrap around the memory.
  function automatic logic [LOG_SIZE-1:0] blk_addr(input logic [LOG_SIZE-1:0] base,
                                                    input logic [LOG_SIZE-1:0] idx);
    logic [31:0] prod;
    prod = 32'(idx) * 32'(BLOCKS);
    return base + prod[LOG_SIZE-1:0];
  endfunction

  function automatic logic [CELL_WIDTH-1:0] status_word(input logic ok, input logic err,
                                                         input logic [LOG_SIZE-1:0] blocks);
    logic [CELL_WIDTH-1:0] w;
    w = '0;
    w[CELL_WIDTH-1]  = ok;
    w[CELL_WIDTH-2]  = err;
    w[LOG_SIZE-1:0]  = blocks;
    return w;
  endfunction

  // Outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_count     <= '0;
      r_k         <= '0;
      r_lat       <= '0;
      r_addr      <= '0;
      r_mem_data  <= '0;
      r_rd_data   <= '0;
      r_status    <= '0;
      r_read_en   <= 1'b0;
      r_write_en  <= 1'b0;
      r_status_en <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_read_en   <= 1'b0;
      r_write_en  <= 1'b0;
      r_status_en <= 1'b0;
      r_addr      <= '0;
      r_status    <= '0;
      r_done      <= 1'b0;
`ifdef MEM_SEQ_ABORT_EN
      if (in_abort && r_state inside {S_RD, S_WAIT, S_PRESENT, S_COLLECT, S_WR}) begin
        // A write strobed in this WR cycle has landed, so it counts as written.
        r_state     <= S_STATUS;
        r_status_en <= 1'b1;
        r_status    <= status_word(1'b0, 1'b1, (r_state == S_WR) ? w_k_next : r_k);
        r_rd_valid  <= 1'b0;
        r_wr_ready  <= 1'b0;
      end else
`endif
      case (r_state)
        S_IDLE: begin
          if (in_start) begin
            r_src   <= in_src_addr;
            r_dst   <= in_dst_addr;
            r_count <= in_count;
            r_k     <= '0;
            if (!in_mem_config[0]) begin
              r_state     <= S_STATUS;
              r_status_en <= 1'b1;
              r_status    <= status_word(1'b0, 1'b1, '0);
            end else if (in_count == '0) begin
              r_state     <= S_STATUS;
              r_status_en <= 1'b1;
              r_status    <= status_word(1'b1, 1'b0, '0);
            end else begin
              r_state   <= S_RD;
              r_read_en <= 1'b1;
              r_addr    <= in_src_addr;
            end
          end
        end
        S_RD: begin
          r_lat   <= 3'd1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat == 3'(READ_LATENCY)) begin
            r_rd_data  <= in_mem_data;
            r_rd_valid <= 1'b1;
            r_state    <= S_PRESENT;
          end else begin
            r_lat <= r_lat + 3'd1;
          end
        end
        S_PRESENT: begin
          if (in_rd_ready) begin
            r_rd_valid <= 1'b0;
            r_wr_ready <= 1'b1;
            r_state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (in_wr_valid) begin
            r_mem_data <= in_wr_data;
            r_wr_ready <= 1'b0;
            r_write_en <= 1'b1;
            r_addr     <= blk_addr(r_dst, r_k);
            r_state    <= S_WR;
          end
        end
        S_WR: begin
          r_k <= w_k_next;
          if (w_k_next == r_count) begin
            r_state     <= S_STATUS;
            r_status_en <= 1'b1;
            r_status    <= status_word(1'b1, 1'b0, w_k_next);
          end else begin
            r_state   <= S_RD;
            r_read_en <= 1'b1;
            r_addr    <= blk_addr(r_src, w_k_next);
          end
        end
        S_STATUS: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_busy                = (r_state != S_IDLE);
  assign out_done                = r_done;
  assign out_mem_address         = r_addr;
  assign out_mem_data            = r_mem_data;
  assign out_mem_read_en         = r_read_en;
  assign out_mem_write_en        = r_write_en;
  assign out_mem_status          = r_status;
  assign out_mem_write_status_en = r_status_en;
  assign out_rd_data             = r_rd_data;
  assign out_rd_valid            = r_rd_valid;
  assign out_wr_ready            = r_wr_ready;

endmodule
